serial_adder: RTL and testbench

Bit-serial N-bit adder that sits directly upstream of the single-bit `full_adder` cell and drives it one bit per clock. The block accepts two operands and a carry-in over a valid/ready handshake. It then shifts the operands LSB-first through one `full_adder` instance while a carry flop feeds `c_out` back into `c_in`. It presents the N-bit sum and final carry-out over a second valid/ready handshake. It is the area-minimal alternative to a ripple adder built from N `full_adder` cells.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the serial adder time-multiplexes one of these across all bits.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full_adder,
// with a carry flop closing the loop, and the result is offered over valid/ready.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_full_adder (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // cnt saturates on the final bit so it never wraps past WIDTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt != LAST_BIT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum   = sum_sh;
    assign c_out = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operations on an 8-bit
// instance plus an exhaustive back-to-back sweep on a 2-bit instance.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
    logic [1:0] a2, b2, sum2;

    int n_checks = 0;
    int n_fail   = 0;

    int edge_cnt  = 0;
    int acc_edge8 = -1;
    int out_edge8 = -1;
    int acc_cnt2  = 0;
    int res_cnt2  = 0;
    int acc_edge2 [32];
    logic [2:0] res2 [32];

    logic [8:0] exp_res;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .c_in      (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .c_out     (cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .c_in      (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .c_out     (cout2)
    );

    // Handshake monitor: records the edge number of every accept / result transfer
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (in_valid8 && in_ready8) acc_edge8 <= edge_cnt + 1;
        if (out_valid8 && out_ready8) out_edge8 <= edge_cnt + 1;
        if (in_valid2 && in_ready2 && acc_cnt2 < 32) begin
            acc_edge2[acc_cnt2] <= edge_cnt + 1;
            acc_cnt2 <= acc_cnt2 + 1;
        end
        if (out_valid2 && out_ready2 && res_cnt2 < 32) begin
            res2[res_cnt2] <= {cout2, sum2};
            res_cnt2 <= res_cnt2 + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic setExpected(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        exp_res = 9'(ta) + 9'(tb_) + 9'(tc);
    endtask

    // Presents one operand set; returns at the negedge following the accepting edge
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        @(negedge clk);
        a8 = ta;
        b8 = tb_;
        cin8 = tc;
        in_valid8 = 1'b1;
        setExpected(ta, tb_, tc);
        checkOutput("in_ready_before_accept", 32'(in_ready8), 32'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
    endtask

    task automatic waitResult();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) checkOutput($sformatf("out_valid_low_e%0d", k), 32'(out_valid8), 32'd0);
        end
        checkOutput("out_valid_high_e8", 32'(out_valid8), 32'd1);
        checkOutput("in_ready_low_done", 32'(in_ready8), 32'd0);
        checkOutput("sum", 32'(sum8), 32'(exp_res[7:0]));
        checkOutput("c_out", 32'(cout8), 32'(exp_res[8]));
    endtask

    task automatic consume();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput("out_valid_after_take", 32'(out_valid8), 32'd0);
        checkOutput("in_ready_after_take", 32'(in_ready8), 32'd1);
    endtask

    task automatic doOp(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        applyStimulus(ta, tb_, tc);
        waitResult();
        consume();
    endtask

    initial begin
        logic saw_valid;
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid8), 32'd0);
        checkOutput("rst_sum", 32'(sum8), 32'd0);
        checkOutput("rst_c_out", 32'(cout8), 32'd0);
        checkOutput("rst_in_ready_w2", 32'(in_ready2), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid8), 32'd0);

        doOp(8'h00, 8'h00, 1'b0);
        checkOutput("latency_edges", 32'(out_edge8 - acc_edge8), 32'd9);
        doOp(8'hFF, 8'h01, 1'b0);
        doOp(8'hA5, 8'h5A, 1'b1);

        // Backpressure: result must hold while new operands are offered and refused
        applyStimulus(8'h12, 8'h34, 1'b0);
        waitResult();
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid8), 32'd1);
            checkOutput("bp_sum", 32'(sum8), 32'h46);
            checkOutput("bp_c_out", 32'(cout8), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        checkOutput("bp_accept_spacing", 32'(acc_edge8), 32'(out_edge8 + 1));
        setExpected(8'hFF, 8'hFF, 1'b0);
        waitResult();
        consume();

        // Reset pulse during RUN abandons the operation
        applyStimulus(8'h55, 8'h66, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("midrun_rst_out_valid", 32'(out_valid8), 32'd0);
        checkOutput("midrun_rst_sum", 32'(sum8), 32'd0);
        checkOutput("midrun_rst_c_out", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrun_release_in_ready", 32'(in_ready8), 32'd1);
        saw_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid8) saw_valid = 1'b1;
        end
        checkOutput("midrun_no_out_valid", 32'(saw_valid), 32'd0);
        doOp(8'h0F, 8'h01, 1'b0);

        for (int r = 0; r < 16; r++) begin
            doOp(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // WIDTH=2 exhaustive sweep, back-to-back with out_ready held high
        out_ready2 = 1'b1;
        in_valid2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] combo;
            combo = 5'(i);
            a2 = combo[4:3];
            b2 = combo[2:1];
            cin2 = combo[0];
            for (int t = 0; t < 8 && acc_cnt2 <= i; t++) @(negedge clk);
            checkOutput($sformatf("sweep_accept_%0d", i), 32'(acc_cnt2), 32'(i + 1));
        end
        in_valid2 = 1'b0;
        for (int t = 0; t < 20 && res_cnt2 < 32; t++) @(negedge clk);
        checkOutput("sweep_result_count", 32'(res_cnt2), 32'd32);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] combo;
            combo = 5'(i);
            checkOutput($sformatf("sweep_result_%0d", i), 32'(res2[i]),
                        32'(combo[4:3]) + 32'(combo[2:1]) + 32'(combo[0]));
            if (i > 0)
                checkOutput($sformatf("sweep_spacing_%0d", i),
                            32'(acc_edge2[i] - acc_edge2[i-1]), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
